// File: rtl/mem_burst_arb_pkg.sv
// Shared cache/memory interface types and geometry for the cache-to-RAM burst path.
// Module parameters default to these values and must stay equal to them.
package cache_parameters;

  localparam int BLOCK_SIZE   = 4;
  localparam int WORD_WIDTH   = 32;
  localparam int ADDR_WIDTH   = 8;
  localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);

  typedef struct packed {
    logic                                 cs;
    logic                                 rw;
    logic [ADDR_WIDTH-1:0]                addr;
    logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] data;
  } memory_request_t;

  typedef struct packed {
    logic                                 ack;
    logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] data;
  } memory_response_t;

endpackage

// File: rtl/mem_burst_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the requests, searching from the port
// after the last accepted grant. The pointer only moves when advance is high.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_d      = PW'((idx + 1) % N);
      end
    end
    if (!advance) ptr_d = ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_burst_arb.sv
// Arbitrates block-sized cache requests from several ports onto one word-wide
// single-port RAM, one word per cycle, and returns read blocks per port.
module mem_burst_arb
  import cache_parameters::*;
#(
  parameter int N_PORTS    = 2,
  parameter int BLOCK_SIZE = cache_parameters::BLOCK_SIZE,
  parameter int WORD_WIDTH = cache_parameters::WORD_WIDTH,
  parameter int ADDR_WIDTH = cache_parameters::ADDR_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  memory_request_t       mem_req [N_PORTS],
  output memory_response_t      mem_res [N_PORTS],
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WORD_WIDTH-1:0] ram_wdata,
  output logic                  ram_wren,
  input  logic [WORD_WIDTH-1:0] ram_q
);

  localparam int KW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN, RESP} state_t;

  state_t                                state_q, state_d;
  logic [KW-1:0]                         k_q, k_d;
  logic [1:0]                            drn_q, drn_d;
  logic                                  rw_q;
  logic [ADDR_WIDTH-1:0]                 addr_q;
  logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] wdata_q;
  logic [PW-1:0]                         gidx_q, gsel;
  logic [N_PORTS-1:0]                    cs_vec, grant;
  logic                                  advance;

  // Read-return pipeline: word index and valid travel alongside the RAM latency.
  logic [RD_LATENCY-1:0]                 vld_q;
  logic [KW-1:0]                         idx_q [RD_LATENCY];
  logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] rdata_q [N_PORTS];

  rr_arbiter #(.N(N_PORTS)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (cs_vec),
    .advance (advance),
    .grant   (grant)
  );

  always_comb begin
    gsel = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant[i]) gsel = PW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    drn_d     = drn_q;
    advance   = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wren  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|cs_vec) begin
          advance = 1'b1;
          k_d     = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        ram_addr  = addr_q + ADDR_WIDTH'(k_q);
        ram_wren  = rw_q;
        ram_wdata = wdata_q[k_q];
        k_d       = k_q + KW'(1);
        if (k_q == KW'(BLOCK_SIZE - 1)) begin
          k_d     = '0;
          drn_d   = '0;
          state_d = rw_q ? RESP : DRAIN;
        end
      end
      DRAIN: begin
        drn_d = drn_q + 2'd1;
        if (drn_q == 2'(RD_LATENCY - 1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      drn_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      drn_q   <= drn_d;
      if (advance) begin
        rw_q    <= mem_req[gsel].rw;
        addr_q  <= ADDR_WIDTH'(mem_req[gsel].addr);
        wdata_q <= (BLOCK_SIZE * WORD_WIDTH)'(mem_req[gsel].data);
        gidx_q  <= gsel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q[0] <= 1'b0;
      idx_q[0] <= '0;
    end else begin
      vld_q[0] <= (state_q == BURST) && !rw_q;
      idx_q[0] <= k_q;
    end
  end

  for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_pipe
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q[gi] <= 1'b0;
        idx_q[gi] <= '0;
      end else begin
        vld_q[gi] <= vld_q[gi-1];
        idx_q[gi] <= idx_q[gi-1];
      end
    end
  end

  // Returned words land straight in the granted port's response register, so
  // writes and other ports' reads never disturb it.
  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q[gi] <= '0;
      end else if (vld_q[RD_LATENCY-1] && (gidx_q == PW'(gi))) begin
        rdata_q[gi][idx_q[RD_LATENCY-1]] <= ram_q;
      end
    end

    assign cs_vec[gi]       = mem_req[gi].cs;
    assign mem_res[gi].ack  = (state_q == RESP) && (gidx_q == PW'(gi));
    assign mem_res[gi].data = rdata_q[gi];
  end

endmodule

// File: tb/tb_mem_burst_arb.sv
// Scoreboard bench: two arbiters (read latency 1 and 3) on behavioural RAMs;
// stimulus queues expected RAM accesses and acks, a negedge monitor checks them.
module tb_mem_burst_arb;
  import cache_parameters::*;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic        wren;
    logic [31:0] wdata;
  } addr_exp_t;

  typedef struct {
    int           cyc;
    int           port;
    logic [127:0] data;
  } ack_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  memory_request_t  req1 [2];
  memory_request_t  req3 [2];
  memory_response_t res1 [2];
  memory_response_t res3 [2];

  logic [7:0]   addr_w  [2];
  logic [31:0]  wdata_w [2];
  logic         wren_w  [2];
  logic         ack_w   [2][2];
  logic [127:0] data_w  [2][2];
  logic [31:0]  q1;
  logic [31:0]  q3_p [3];

  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  bit          wr1  [256];
  bit          wr3  [256];

  addr_exp_t aq [2][$];
  ack_exp_t  kq [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_burst_arb #(.N_PORTS(2), .RD_LATENCY(1)) u_dut1 (
    .clk (clk), .rst (rst), .mem_req (req1), .mem_res (res1),
    .ram_addr (addr_w[0]), .ram_wdata (wdata_w[0]), .ram_wren (wren_w[0]), .ram_q (q1)
  );

  mem_burst_arb #(.N_PORTS(2), .RD_LATENCY(3)) u_dut3 (
    .clk (clk), .rst (rst), .mem_req (req3), .mem_res (res3),
    .ram_addr (addr_w[1]), .ram_wdata (wdata_w[1]), .ram_wren (wren_w[1]), .ram_q (q3_p[2])
  );

  assign ack_w[0][0]  = res1[0].ack;
  assign ack_w[0][1]  = res1[1].ack;
  assign ack_w[1][0]  = res3[0].ack;
  assign ack_w[1][1]  = res3[1].ack;
  assign data_w[0][0] = res1[0].data;
  assign data_w[0][1] = res1[1].data;
  assign data_w[1][0] = res3[0].data;
  assign data_w[1][1] = res3[1].data;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    if (a >= 8'h10 && a <= 8'h13) return 32'hA0 + {24'h0, a - 8'h10};
    return {16'hBEEF, 8'h00, a};
  endfunction

  function automatic logic [127:0] pack4(input logic [31:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  // Untouched locations read as init_val, so no preload process is needed.
  always @(posedge clk) begin
    if (wren_w[0]) begin
      mem1[addr_w[0]] <= wdata_w[0];
      wr1[addr_w[0]]  <= 1'b1;
    end
    q1 <= wr1[addr_w[0]] ? mem1[addr_w[0]] : init_val(addr_w[0]);
  end

  always @(posedge clk) begin
    if (wren_w[1]) begin
      mem3[addr_w[1]] <= wdata_w[1];
      wr3[addr_w[1]]  <= 1'b1;
    end
    q3_p[0] <= wr3[addr_w[1]] ? mem3[addr_w[1]] : init_val(addr_w[1]);
    q3_p[1] <= q3_p[0];
    q3_p[2] <= q3_p[1];
  end

  function automatic logic [31:0] ram1_rd(input logic [7:0] a);
    return wr1[a] ? mem1[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
      miscompares++;
    end
  endtask

  task automatic set_req(input int d, input int p, input logic cs, input logic rw,
                         input logic [7:0] addr, input logic [127:0] data);
    memory_request_t r;
    r.cs   = cs;
    r.rw   = rw;
    r.addr = addr;
    r.data = data;
    if (d == 0) req1[p] = r;
    else        req3[p] = r;
  endtask

  task automatic drop_cs(input int d, input int p);
    if (d == 0) req1[p].cs = 1'b0;
    else        req3[p].cs = 1'b0;
  endtask

  // Called just after a posedge; wait_c is how many cycles this port waits in
  // IDLE before its cs is actually sampled for a grant.
  task automatic issue(input int d, input int p, input logic rw, input logic [7:0] addr,
                       input logic [127:0] wd, input logic [127:0] exp_data,
                       input int wait_c, input int lat);
    int c0;
    c0 = cyc + wait_c;
    set_req(d, p, 1'b1, rw, addr, wd);
    for (int i = 0; i < 4; i++)
      aq[d].push_back('{cyc: c0 + 1 + i, addr: addr + 8'(i), wren: rw,
                        wdata: wd[32*i +: 32]});
    kq[d].push_back('{cyc: (rw ? c0 + 5 : c0 + 5 + lat), port: p, data: exp_data});
    $display("issue dut%0d port%0d %s addr=%h at cycle %0d", d, p, rw ? "WR" : "RD", addr, c0);
  endtask

  task automatic wait_ack(input int d, input int p);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      seen = ack_w[d][p];
      n++;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout dut%0d port%0d: got no ack, expected ack within 60 cycles", d, p);
    end
    @(posedge clk);
    #1;
    drop_cs(d, p);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (aq[d].size() > 0 && aq[d][0].cyc <= cyc) begin
          addr_exp_t a;
          a = aq[d].pop_front();
          vectors++;
          if (a.cyc != cyc || addr_w[d] !== a.addr || wren_w[d] !== a.wren ||
              (a.wren && wdata_w[d] !== a.wdata)) begin
            miscompares++;
            $display("FAIL ram_access dut%0d cyc%0d: got addr=%h wren=%b wdata=%h, expected cyc%0d addr=%h wren=%b wdata=%h",
                     d, cyc, addr_w[d], wren_w[d], wdata_w[d], a.cyc, a.addr, a.wren, a.wdata);
          end
        end
        if (ack_w[d][0] && ack_w[d][1]) begin
          miscompares++;
          $display("FAIL ack_overlap dut%0d cyc%0d: got acks 11, expected at most one", d, cyc);
        end
        for (int p = 0; p < 2; p++) begin
          if (ack_w[d][p]) begin
            if (kq[d].size() == 0) begin
              miscompares++;
              $display("FAIL unexpected_ack dut%0d port%0d cyc%0d: got ack, expected none", d, p, cyc);
            end else begin
              ack_exp_t e;
              e = kq[d].pop_front();
              vectors++;
              if (e.port != p || e.cyc != cyc || data_w[d][p] !== e.data) begin
                miscompares++;
                $display("FAIL ack dut%0d: got port%0d cyc%0d data=%h, expected port%0d cyc%0d data=%h",
                         d, p, cyc, data_w[d][p], e.port, e.cyc, e.data);
              end else begin
                $display("ack dut%0d port%0d cyc%0d data=%h ok", d, p, cyc, data_w[d][p]);
              end
            end
          end
        end
        if (kq[d].size() > 0 && kq[d][0].cyc < cyc) begin
          ack_exp_t e;
          e = kq[d].pop_front();
          vectors++;
          miscompares++;
          $display("FAIL missing_ack dut%0d: got no ack by cyc%0d, expected port%0d at cyc%0d",
                   d, cyc, e.port, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] blk_a, blk_w, blk_wrap, blk_30, blk_9;
    blk_a    = pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    blk_w    = pack4(32'd1, 32'd2, 32'd3, 32'd4);
    blk_wrap = pack4(32'hBEEF00FE, 32'hBEEF00FF, 32'hBEEF0000, 32'hBEEF0001);
    blk_9    = pack4(32'd9, 32'd9, 32'd9, 32'd9);
    blk_30   = pack4(32'd9, 32'hBEEF0031, 32'hBEEF0032, 32'hBEEF0033);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) set_req(d, p, 1'b0, 1'b0, 8'h00, 128'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_acks", {126'h0, ack_w[0][0], ack_w[0][1]}, 128'h0);
    chk("rst_ram_addr", {120'h0, addr_w[0]}, 128'h0);
    chk("rst_ram_wren", {127'h0, wren_w[0]}, 128'h0);
    chk("rst_data_p0", data_w[0][0], 128'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single read, then write + read-back on port 1
    issue(0, 0, 1'b0, 8'h10, 128'h0, blk_a, 0, 1);
    wait_ack(0, 0);
    issue(0, 1, 1'b1, 8'h20, blk_w, 128'h0, 0, 1);
    wait_ack(0, 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("ram_20_%0d", i), {96'h0, ram1_rd(8'h20 + 8'(i))}, 128'(i + 1));
    issue(0, 1, 1'b0, 8'h20, 128'h0, blk_w, 0, 1);
    wait_ack(0, 1);

    // contention, two rounds: port 0 then port 1 each time
    issue(0, 0, 1'b0, 8'h10, 128'h0, blk_a, 0, 1);
    issue(0, 1, 1'b0, 8'h20, 128'h0, blk_w, 7, 1);
    fork
      wait_ack(0, 0);
      wait_ack(0, 1);
    join
    issue(0, 0, 1'b0, 8'h20, 128'h0, blk_w, 0, 1);
    issue(0, 1, 1'b0, 8'h10, 128'h0, blk_a, 7, 1);
    fork
      wait_ack(0, 0);
      wait_ack(0, 1);
    join

    // address wrap at the top of the 8-bit space
    issue(0, 0, 1'b0, 8'hFE, 128'h0, blk_wrap, 0, 1);
    wait_ack(0, 0);

    // three-cycle read latency
    issue(1, 0, 1'b0, 8'h10, 128'h0, blk_a, 0, 3);
    wait_ack(1, 0);

    // reset during a port-0 write burst, two words in
    set_req(1, 0, 1'b1, 1'b1, 8'h30, blk_9);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_burst_wren", {127'h0, wren_w[1]}, 128'h1);
    chk("mid_burst_addr", {120'h0, addr_w[1]}, 128'h31);
    rst = 1'b1;
    #1;
    chk("async_rst_wren", {127'h0, wren_w[1]}, 128'h0);
    chk("async_rst_addr", {120'h0, addr_w[1]}, 128'h0);
    chk("async_rst_wdata", {96'h0, wdata_w[1]}, 128'h0);
    chk("async_rst_acks", {126'h0, ack_w[1][0], ack_w[1][1]}, 128'h0);
    chk("async_rst_data_p0", data_w[1][0], 128'h0);
    drop_cs(1, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // pointer back at port 0; port 1 sees the partially written block
    issue(1, 0, 1'b0, 8'h10, 128'h0, blk_a, 0, 3);
    issue(1, 1, 1'b0, 8'h30, 128'h0, blk_30, 9, 3);
    fork
      wait_ack(1, 0);
      wait_ack(1, 1);
    join

    repeat (5) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (aq[d].size() != 0 || kq[d].size() != 0) begin
        miscompares++;
        $display("FAIL leftover dut%0d: got %0d accesses and %0d acks pending, expected 0 and 0",
                 d, aq[d].size(), kq[d].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_burst_arb.md
MEM_BURST_ARB -- requirements
Module: mem_burst_arb

Interface
REQ-001 Parameter N_PORTS, default 2, number of cache requesters (I-cache, D-cache), range 1..4.
REQ-002 Parameter BLOCK_SIZE, default cache_parameters::BLOCK_SIZE, words per burst, power of two, at least 2.
REQ-003 Parameter WORD_WIDTH, default cache_parameters::WORD_WIDTH, data word width.
REQ-004 Parameter ADDR_WIDTH, default cache_parameters::ADDR_WIDTH, word address width.
REQ-005 Parameter RD_LATENCY, default 1, RAM clock-to-q read latency in cycles, range 1..4.
REQ-006 Port clk, input, 1, single clock, rising edge; all logic runs in this one domain.
REQ-007 Port rst, input, 1, reset, asynchronous and active-high.
REQ-008 Port mem_req, input, memory_request_t[N_PORTS], per port: cs, rw (1=write), addr (block base), data[BLOCK_SIZE].
REQ-009 Port mem_res, output, memory_response_t[N_PORTS], per port: ack, data[BLOCK_SIZE].
REQ-010 Port ram_addr, output, ADDR_WIDTH, RAM word address.
REQ-011 Port ram_wdata, output, WORD_WIDTH, RAM write data.
REQ-012 Port ram_wren, output, 1, RAM write enable.
REQ-013 Port ram_q, input, WORD_WIDTH, RAM read data, valid RD_LATENCY cycles after its address.

Function
REQ-014 FSM states IDLE, BURST, DRAIN and RESP, registered, with no other states.
REQ-015 IDLE: if any cs=1, grant one port round-robin, latch its rw, addr and data, clear the word counter k, go to BURST; else stay.
REQ-016 Round-robin: priority starts at the port after the last granted one; after reset port 0 has highest priority.
REQ-017 BURST: one word per cycle, ram_addr = base + k modulo 2^ADDR_WIDTH (wrap allowed), ram_wren = rw, ram_wdata = latched data[k]; k increments.
REQ-018 Read: the ram_q word for index k is captured into buffer[k] exactly RD_LATENCY cycles after issue (delayed index/valid pipeline).
REQ-019 After index BLOCK_SIZE-1 is issued: a read goes to DRAIN for RD_LATENCY cycles then RESP; a write goes directly to RESP.
REQ-020 Outside BURST: ram_wren = 0, ram_addr = 0, ram_wdata = 0.
REQ-021 RESP: ack = 1 for exactly one cycle on the granted port only, then IDLE.
REQ-022 Read latency from cs sampled in IDLE to the ack cycle = BLOCK_SIZE + RD_LATENCY + 1 cycles; write latency = BLOCK_SIZE + 1.
REQ-023 mem_res[p].data is registered; it is updated only by reads granted to port p and holds its value until the next such read.
REQ-024 On a write ack, mem_res[p].data keeps its previous value.
REQ-025 Request fields are sampled only in IDLE; changing or dropping cs mid-transaction does not abort it, and ack is still issued.
REQ-026 A requester keeps cs high until ack and drops it the cycle after; cs still high in IDLE is a new request, arbitrated normally.
REQ-027 Simultaneous cs on several ports: one grant per transaction; a waiting port is served within N_PORTS-1 transactions.
REQ-028 ack is never asserted on two ports in the same cycle.

Reset
REQ-029 rst asserted at any time, including mid-burst, forces within the same cycle: state IDLE, k = 0, pipeline valid bits cleared, round-robin pointer at port 0.
REQ-030 rst also forces all ack = 0, all mem_res data = 0, and ram_wren/ram_addr/ram_wdata = 0.
REQ-031 An interrupted write may leave a partially written block, and no ack is issued for it.

Structure
REQ-032 memory_request_t, memory_response_t, BLOCK_SIZE, WORD_WIDTH, ADDR_WIDTH and OFFSET_WIDTH come from package cache_parameters.
REQ-033 The FSM state enum is local to the module.
REQ-034 Round-robin grant logic is a sub-module rr_arbiter (parameter N, inputs req/advance, output one-hot grant).
REQ-035 The RAM is instantiated outside this block.

Verification
REQ-036 Single read, N_PORTS=2, BLOCK_SIZE=4, RD_LATENCY=1, RAM[0x10..0x13] = A0..A3, port0 read addr 0x10 -> ram_addr 0x10..0x13 on 4 consecutive cycles, port0 ack at cycle 6 with data {A0,A1,A2,A3}.
REQ-037 Write then read: port1 writes {1,2,3,4} to 0x20 -> ack at cycle 5, RAM 0x20..0x23 = 1..4; port1 read of 0x20 returns {1,2,3,4}.
REQ-038 Contention: port0 and port1 raise cs in the same cycle, twice in a row -> grants port0, port1, port0, port1; acks never overlap.
REQ-039 Wrap: ADDR_WIDTH=8, read at 0xFE -> ram_addr sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-040 RD_LATENCY=3 read -> ack at cycle BLOCK_SIZE+4 and data correct; rst pulsed mid-burst -> outputs zero immediately, no ack, next request served normally from IDLE.
